// File: rtl/multicycle_controller.sv
// Sequencing control unit for a multi-cycle RV32I(M) core: fetch/decode/execute/memory/writeback
// with ready-style memory handshakes, optional mul/div handshake and trap redirection.
module multicycle_controller #(
  parameter int M_EXT       = 1,
  parameter int MEM_TIMEOUT = 16,
  parameter int ALU_OP_W    = 5
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [31:0]         instr_i,
  input  logic                imem_ready_i,
  input  logic                dmem_ready_i,
  input  logic                md_done_i,
  input  logic                branch_taken_i,
  output logic                imem_req_o,
  output logic                dmem_req_o,
  output logic                dmem_we_o,
  output logic                md_start_o,
  output logic                ir_wr_en_o,
  output logic                pc_wr_en_o,
  output logic [1:0]          pc_src_o,
  output logic                regf_wr_en_o,
  output logic [1:0]          regf_rd_src_o,
  output logic                alu_src_a_o,
  output logic                alu_src_b_o,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic                trap_o,
  output logic [1:0]          trap_cause_o,
  output logic                retire_o,
  output logic [2:0]          state_o
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MEM_TIMEOUT);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXEC    = 3'd2,
    MD_WAIT = 3'd3,
    MEM     = 3'd4,
    WB      = 3'd5,
    TRAP    = 3'd6
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [1:0]       cause;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_op, is_opimm, is_load, is_store, is_branch;
  logic       is_jal, is_jalr, is_lui, is_auipc, is_md, op_legal, legal;
  logic [4:0] alu_fn;
  logic [1:0] rd_src;
  logic       unused_instr;

  assign opcode       = instr_i[6:0];
  assign funct3       = instr_i[14:12];
  assign funct7       = instr_i[31:25];
  assign unused_instr = ^{instr_i[24:15], instr_i[11:7]};

  assign is_op     = (opcode == OPC_OP);
  assign is_opimm  = (opcode == OPC_OP_IMM);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_lui    = (opcode == OPC_LUI);
  assign is_auipc  = (opcode == OPC_AUIPC);
  assign is_md     = is_op && (funct7 == 7'h01) && (M_EXT != 0);

  // funct7=0x20 is only meaningful for SUB and SRA; anything else in OP is reserved.
  assign op_legal = (funct7 == 7'h00)
                 || ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)))
                 || is_md;
  assign legal = is_opimm || is_load || is_store || is_branch || is_jal || is_jalr
              || is_lui || is_auipc || (is_op && op_legal);

  assign rd_src = is_load                ? 2'b01 :
                  (is_jal || is_jalr)    ? 2'b10 :
                  (is_lui || is_auipc)   ? 2'b11 : 2'b00;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    alu_fn = 5'h00;
    if (is_op && (funct7 == 7'h01)) begin
      alu_fn = {2'b10, funct3};
    end else if (is_op || is_opimm) begin
      case (funct3)
        3'b000:  alu_fn = (is_op && instr_i[30]) ? 5'h01 : 5'h00;
        3'b001:  alu_fn = 5'h05;
        3'b010:  alu_fn = 5'h08;
        3'b011:  alu_fn = 5'h09;
        3'b100:  alu_fn = 5'h02;
        3'b101:  alu_fn = instr_i[30] ? 5'h07 : 5'h06;
        3'b110:  alu_fn = 5'h03;
        default: alu_fn = 5'h04;
      endcase
    end else if (is_branch) begin
      case (funct3)
        3'b000:  alu_fn = 5'h0A;
        3'b001:  alu_fn = 5'h0B;
        3'b100:  alu_fn = 5'h0C;
        3'b101:  alu_fn = 5'h0D;
        3'b110:  alu_fn = 5'h0E;
        3'b111:  alu_fn = 5'h0F;
        default: alu_fn = 5'h00;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; later writes override the default.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= FETCH;
      wait_cnt <= '0;
      cause    <= 2'b00;
    end else begin
      wait_cnt <= (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + CNT_W'(1);
      case (state)
        FETCH: begin
          if (imem_ready_i) begin
            state <= DECODE; wait_cnt <= '0;
          end else if (wait_cnt == CNT_LAST) begin
            state <= TRAP; wait_cnt <= '0; cause <= 2'b10;
          end
        end
        DECODE: begin
          wait_cnt <= '0;
          if (!legal) begin
            state <= TRAP; cause <= 2'b01;
          end else begin
            state <= EXEC;
          end
        end
        EXEC: begin
          wait_cnt <= '0;
          if (is_md)                      state <= MD_WAIT;
          else if (is_load || is_store)   state <= MEM;
          else if (is_branch)             state <= FETCH;
          else                            state <= WB;
        end
        MD_WAIT: begin
          if (md_done_i) begin
            state <= WB; wait_cnt <= '0;
          end
        end
        MEM: begin
          if (dmem_ready_i) begin
            state <= is_load ? WB : FETCH; wait_cnt <= '0;
          end else if (wait_cnt == CNT_LAST) begin
            state <= TRAP; wait_cnt <= '0; cause <= 2'b11;
          end
        end
        WB:      begin state <= FETCH; wait_cnt <= '0; end
        TRAP:    begin state <= FETCH; wait_cnt <= '0; end
        default: begin state <= FETCH; wait_cnt <= '0; end
      endcase
    end
  end

  // Outputs are forced low while reset is held so an abort never leaks a write or retire.
  always_comb begin
    imem_req_o    = 1'b0;
    dmem_req_o    = 1'b0;
    dmem_we_o     = 1'b0;
    md_start_o    = 1'b0;
    ir_wr_en_o    = 1'b0;
    pc_wr_en_o    = 1'b0;
    pc_src_o      = 2'b00;
    regf_wr_en_o  = 1'b0;
    regf_rd_src_o = 2'b00;
    alu_src_a_o   = 1'b0;
    alu_src_b_o   = 1'b0;
    alu_op_o      = '0;
    trap_o        = 1'b0;
    retire_o      = 1'b0;
    if (rst_ni) begin
      if (state inside {DECODE, EXEC, MD_WAIT, MEM, WB}) begin
        alu_op_o      = ALU_OP_W'(alu_fn);
        alu_src_a_o   = is_auipc;
        alu_src_b_o   = !(is_op || is_branch);
        regf_rd_src_o = rd_src;
      end
      case (state)
        FETCH: begin
          imem_req_o = 1'b1;
          ir_wr_en_o = imem_ready_i;
        end
        EXEC: begin
          md_start_o = is_md;
          if (is_branch) begin
            pc_wr_en_o = 1'b1;
            pc_src_o   = branch_taken_i ? 2'b01 : 2'b00;
            retire_o   = 1'b1;
          end
        end
        MEM: begin
          dmem_req_o = 1'b1;
          dmem_we_o  = is_store;
          if (dmem_ready_i && is_store) begin
            pc_wr_en_o = 1'b1;
            retire_o   = 1'b1;
          end
        end
        WB: begin
          regf_wr_en_o = 1'b1;
          pc_wr_en_o   = 1'b1;
          retire_o     = 1'b1;
          pc_src_o     = is_jal ? 2'b01 : (is_jalr ? 2'b10 : 2'b00);
        end
        TRAP: begin
          trap_o     = 1'b1;
          pc_wr_en_o = 1'b1;
          pc_src_o   = 2'b11;
        end
        default: ;
      endcase
    end
  end

  assign trap_cause_o = cause;
  assign state_o      = state;

endmodule
